// File: rtl/bram_stream_reader.sv
// Streams a contiguous, wrapping address range out of a block RAM read port onto
// a valid/ready stream, hiding the RAM's one-cycle registered read latency.
module bram_stream_reader #(
  parameter int memSize_p   = 8,
  parameter int dataWidth_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [memSize_p-1:0]   base_i,
  input  logic [memSize_p:0]     length_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [memSize_p-1:0]   raddr_o,
  input  logic [dataWidth_p-1:0] rdata_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [dataWidth_p-1:0] data_o
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  localparam logic [memSize_p-1:0] ADDR_ONE = {{(memSize_p-1){1'b0}}, 1'b1};
  localparam logic [memSize_p:0]   CNT_ONE  = {{memSize_p{1'b0}}, 1'b1};

  logic [0:0]             state;
  logic [memSize_p-1:0]   addr;
  logic [memSize_p:0]     remaining;
  logic [memSize_p:0]     outstanding;
  logic                   inflight;
  logic                   done_q;
  logic [dataWidth_p-1:0] buf_q [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             count;

  logic       push;
  logic       pop;
  logic       issue;
  logic       accept;
  logic       accept_zero;
  logic       last;
  logic [2:0] occupancy;

  // Occupancy counts the word already on its way from the RAM, so the buffer
  // can never be pushed while full.
  always_comb begin
    push        = inflight;
    pop         = (count != 2'd0) && ready_i;
    occupancy   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue       = (state == STREAM) && !abort_i && (remaining != '0) && (occupancy < 3'd2);
    accept      = (state == IDLE) && start_i && !abort_i && (length_i != '0);
    accept_zero = (state == IDLE) && start_i && !abort_i && (length_i == '0);
    last        = (state == STREAM) && !abort_i && pop && (outstanding == CNT_ONE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      addr        <= '0;
      remaining   <= '0;
      outstanding <= '0;
      inflight    <= 1'b0;
      done_q      <= 1'b0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      done_q <= accept_zero || last;
      if (abort_i) begin
        state       <= IDLE;
        remaining   <= '0;
        outstanding <= '0;
        inflight    <= 1'b0;
        wr_ptr      <= 1'b0;
        rd_ptr      <= 1'b0;
        count       <= 2'd0;
      end else begin
        inflight <= issue;
        if (accept) begin
          state       <= STREAM;
          addr        <= base_i;
          remaining   <= length_i;
          outstanding <= length_i;
        end
        if (issue) begin
          addr      <= addr + ADDR_ONE;
          remaining <= remaining - CNT_ONE;
        end
        if ((state == STREAM) && pop) begin
          outstanding <= outstanding - CNT_ONE;
        end
        if (last) begin
          state <= IDLE;
        end
        if (push) begin
          buf_q[wr_ptr] <= rdata_i;
          wr_ptr        <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  always_comb begin
    busy_o  = (state == STREAM);
    done_o  = done_q;
    raddr_o = addr;
    valid_o = (count != 2'd0);
    data_o  = buf_q[rd_ptr];
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side streaming engine for the dual-port inferred block RAM. On a start command it walks a contiguous, wrapping address range on the RAM read port, absorbs the RAM's one-cycle registered read latency, and presents each word on a valid/ready stream with full throughput and no loss under backpressure. It sits between the RAM read port (`raddr_i`/`data_o` of the RAM) and any downstream consumer, such as a UART TX or display feeder, while the RAM write port stays with the producer.

## Interface
- `memSize_p`, 8: RAM address width; the RAM depth is 2**memSize_p.
- `dataWidth_p`, 16: word width.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  start command, sampled only while idle.
- `base_i`  in  memSize_p  first address, captured on an accepted start.
- `length_i`  in  memSize_p+1  word count 0..2**memSize_p, captured on an accepted start.
- `abort_i`  in  1  synchronous flush.
- `busy_o`  out  1  transfer in progress.
- `done_o`  out  1  one-cycle pulse after the final word is accepted.
- `raddr_o`  out  memSize_p  to the RAM read address.
- `rdata_i`  in  dataWidth_p  from the RAM data output; valid the cycle after the matching `raddr_o`.
- `valid_o`  out  1  stream word available.
- `ready_i`  in  1  consumer accepts.
- `data_o`  out  dataWidth_p  stream word.

## Operation
- **FSM states.**
  - IDLE: `start_i`=1 with `length_i`>0 → STREAM. `start_i`=1 with `length_i`=0 → pulse `done_o` next cycle, `busy_o` stays 0.
  - STREAM: after the last word handshake → IDLE. `abort_i` → IDLE.
- **Registers.**
  - `addr` (memSize_p bits) drives `raddr_o` directly.
  - `remaining` (memSize_p+1 bits) counts reads not yet issued.
  - `outstanding` (memSize_p+1 bits) counts words not yet accepted.
  - `inflight` is a 1-bit flag.
  - The output buffer is a 2-entry FIFO; `data_o` is its head.
- **Read issue.** A read issues in STREAM when `remaining`>0 and (buffer count + `inflight` − pop) < 2, where pop = `valid_o` & `ready_i`. On issue:
  - `addr` increments modulo 2**memSize_p, so base 0xFE with length 4 reads 0xFE, 0xFF, 0x00, 0x01.
  - `remaining` decrements.
  - `inflight` is set for the next cycle.
- **Capture and output.**
  - When `inflight`=1, `rdata_i` is pushed into the buffer at that edge.
  - `valid_o` = buffer non-empty.
  - A simultaneous push and pop is legal and keeps the count unchanged.
- **Completion.** Each handshake decrements `outstanding`. When it reaches 0, the FSM goes to IDLE, `busy_o` drops and `done_o` pulses in the same cycle.
- **Start while busy.** `start_i` in STREAM is ignored.
- **`abort_i`.**
  - Clears the buffer, `inflight`, `remaining` and `outstanding`, and returns to IDLE.
  - No `done_o` is produced.
  - `abort_i` has priority over `start_i` in the same cycle.
- **`valid_o` stability.** Once asserted, `valid_o` and `data_o` hold until accepted (standard valid/ready). Only `abort_i` or reset may withdraw them.
- **`raddr_o` when no read issues.** `raddr_o` holds its value; the RAM read is harmless.
- **RAM write-through.** Same-cycle write collisions are resolved by the RAM's own write-through. This block needs no special handling.

## Timing
- **Reset values.** `busy_o`=0, `done_o`=0, `valid_o`=0, `data_o`=0, `raddr_o`=0, buffer empty, FSM=IDLE. Reset takes effect immediately, mid-transfer included.
- **Start latency.** Start accepted at edge T0:
  - cycle 1: `busy_o`=1, `raddr_o`=base, first read issues.
  - edge T2: capture.
  - cycle 3: `valid_o`=1, `data_o`=mem[base].
  - So first data appears 3 cycles after start.
- **Throughput.** With `ready_i` held high, one word per cycle. N words occupy cycles 3..N+2. `done_o`=1 and `busy_o`=0 in cycle N+3.
- **Backpressure.** `ready_i` low for K cycles: the buffer fills to 2 and issue stalls. No word is dropped or duplicated. Streaming resumes at full rate the cycle `ready_i` returns.
- **Back-to-back transfers.** A new start is accepted in the `done_o` cycle, since the FSM is already IDLE.

## Test plan
- **Full-rate stream.** RAM preloaded with mem[a]=a+0x100. start base=0x10, length=4, `ready_i`=1 → `data_o` 0x110, 0x111, 0x112, 0x113 in cycles 3–6, `done_o` in cycle 7.
- **Wrap-around.** base=0xFE, length=4 → 0x1FE, 0x1FF, 0x100, 0x101.
- **Backpressure.** length=6, `ready_i` toggled 1,0,0,1,0,1… → exactly 6 handshakes, in order, `data_o` stable while stalled, buffer count ≤2.
- **Zero length and busy start.** length=0 → `done_o` pulse at cycle 1 with `busy_o` never high. A start asserted during STREAM → ignored, and the first transfer completes unchanged.
- **Abort.** `abort_i` in cycle 4 of a length=8 transfer → `valid_o`=0 next cycle, no `done_o`, new start base=0 length=1 → 0x100.
- **Full depth and async reset.** length=256 → 256 words, `done_o` once. `reset_i` pulsed asynchronously mid-transfer → all outputs at reset values before the next edge.
